instruction_fetch_unit: RTL and testbench
=========================================

// Module: instruction_fetch_unit
// PURPOSE
//  Fetch initiator for the byte-addressed, big-endian, combinational-read instruction memory.
//  - Owns the fetch PC and drives the memory address.
//  - Buffers fetched words with their PCs in a small FIFO.
//  - Presents them to decode over a valid/ready handshake.
//  - Accepts branch/jump redirects that flush the buffer.
// PARAMETERS
//  RESET_PC  32'h0000_0000  fetch PC loaded on reset
//  QDEPTH    2              instruction queue entries (>=2)
// PORTS
//  clk             in   1   rising-edge clock
//  rst             in   1   synchronous, active-high reset
//  imem_addr       out  32  byte address to instruction memory; always == fetch_pc
//  imem_inst       in   32  instruction word returned combinationally for imem_addr
//  redirect_valid  in   1   load new fetch PC and flush queue at this edge
//  redirect_pc     in   32  redirect target; bits[1:0] ignored (forced 0)
//  out_valid       out  1   queue head holds a valid instruction
//  out_ready       in   1   decode accepts head this cycle
//  out_inst        out  32  head instruction word
//  out_pc          out  32  head instruction byte address
//  out_pc_plus4    out  32  out_pc + 4 (combinational, mod 2^32)
// BEHAVIOUR
//  - Reset (sync, rst=1 at edge):
//    - fetch_pc <= RESET_PC; queue count <= 0.
//    - out_valid=0; out_inst/out_pc = 0.
//    - Overrides redirect and handshake.
//  - pop = out_valid & out_ready.
//  - push = (count < QDEPTH) | pop.
//    - Enqueues {imem_inst, fetch_pc} at the tail.
//    - fetch_pc <= fetch_pc + 4, wrapping mod 2^32 (0xFFFF_FFFC -> 0x0).
//  - Push and pop in the same cycle: count unchanged, full throughput of one instruction per cycle.
//  - Full and no pop: no push; fetch_pc holds, so imem_addr is stable.
//  - out_valid = (count != 0). Head fields come from registered queue storage.
//  - While out_valid=1 and out_ready=0, out_inst/out_pc are held stable.
//  - Latency: the word at fetch_pc is visible on out_* one cycle after the edge that enqueues it.
//    - First valid cycle after reset release is cycle 1.
//  - Redirect (redirect_valid=1 at edge, rst=0):
//    - count <= 0; fetch_pc <= {redirect_pc[31:2], 2'b00}.
//    - Any concurrent push is discarded.
//    - A concurrent pop is still a completed handshake for decode; the entry is simply gone.
//  - After a redirect: out_valid=0 for exactly one cycle, then the target instruction appears.
//  - Redirect during backpressure (queue full): flush wins, same timing.
//  - Back-to-back redirects: the last one wins, and out_valid stays 0 while redirect_valid is held.
//  - The memory decodes addr[9:0] only, so PCs above 1023 alias.
//    - out_pc still reports the full 32-bit PC.
//  - Queue pointers wrap modulo QDEPTH; count is kept in the range 0..QDEPTH.
// TESTING
//  - Stream: mem[0]=LW (0x8C220000), mem[4]=ADD (0x00221820); rst 1 cycle, out_ready=1
//    -> cycle1: out_valid=1, out_pc=0, out_inst=0x8C220000.
//    -> cycle2: out_pc=4, out_inst=0x00221820, out_pc_plus4=8.
//  - Backpressure: out_ready=0 from reset
//    -> count reaches 2; imem_addr holds 8; out_pc stays 0.
//    -> raise out_ready: out_pc = 0, 4, 8 on consecutive cycles, no gap.
//  - Redirect with full queue: redirect_pc=0x40
//    -> next cycle out_valid=0, imem_addr=0x40.
//    -> following cycle out_valid=1, out_pc=0x40.
//  - Misaligned redirect 0x43 -> out_pc=0x40; redirect and pop same edge -> popped entry never re-presented.
//  - Reset mid-stream at fetch_pc=0x20 -> next cycle out_valid=0, imem_addr=RESET_PC.
//  - Wrap: redirect 0xFFFF_FFFC -> out_pc 0xFFFF_FFFC then 0x0000_0000; out_pc_plus4 of first = 0x0.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the fetch PC, buffers fetched words with their PCs in a
// small queue and hands them to decode over valid/ready; redirects flush the queue.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_inst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  output logic [31:0] out_pc_plus4
);

  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = $clog2(QDEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(QDEPTH);
  localparam logic [PW-1:0] LAST_C  = PW'(QDEPTH - 1);

  logic [31:0]   fetch_pc_reg, fetch_pc_next;
  logic [PW-1:0] head_reg, head_next;
  logic [PW-1:0] tail_reg, tail_next;
  logic [CW-1:0] count_reg, count_next;
  logic [31:0]   inst_q [QDEPTH];
  logic [31:0]   pc_q   [QDEPTH];
  logic          pop;
  logic          push;
  logic          write_en;
  logic          unused_pc_bits;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_C) ? '0 : p + PW'(1);
  endfunction

  // A pop always frees a slot, so a full queue can still accept this cycle's fetch.
  assign pop      = out_valid & out_ready;
  assign push     = (count_reg < DEPTH_C) | pop;
  assign write_en = push & ~redirect_valid;

  always_comb begin
    fetch_pc_next = fetch_pc_reg;
    head_next     = head_reg;
    tail_next     = tail_reg;
    count_next    = count_reg;
    if (redirect_valid) begin
      fetch_pc_next = {redirect_pc[31:2], 2'b00};
      head_next     = '0;
      tail_next     = '0;
      count_next    = '0;
    end else begin
      if (push) begin
        fetch_pc_next = fetch_pc_reg + 32'd4;
        tail_next     = ptr_inc(tail_reg);
      end
      if (pop) begin
        head_next = ptr_inc(head_reg);
      end
      if (push && !pop) begin
        count_next = count_reg + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_reg <= RESET_PC;
      head_reg     <= '0;
      tail_reg     <= '0;
      count_reg    <= '0;
    end else begin
      fetch_pc_reg <= fetch_pc_next;
      head_reg     <= head_next;
      tail_reg     <= tail_next;
      count_reg    <= count_next;
    end
  end

  // Storage is cleared on reset so the head fields read zero until the first fetch lands.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < QDEPTH; i++) begin
        inst_q[i] <= '0;
        pc_q[i]   <= '0;
      end
    end else if (write_en) begin
      inst_q[tail_reg] <= imem_inst;
      pc_q[tail_reg]   <= fetch_pc_reg;
    end
  end

  assign imem_addr      = fetch_pc_reg;
  assign out_valid      = (count_reg != '0);
  assign out_inst       = inst_q[head_reg];
  assign out_pc         = pc_q[head_reg];
  assign out_pc_plus4   = out_pc + 32'd4;
  assign unused_pc_bits = ^redirect_pc[1:0];

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: per-cycle vector table plus a random
// backpressure run checked against an in-order PC scoreboard.
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] imem_addr;
  logic [31:0] imem_inst;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic [31:0] out_pc_plus4;

  int n_checks = 0;
  int n_fail   = 0;

  instruction_fetch_unit #(.RESET_PC(32'h0000_0000), .QDEPTH(2)) dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_inst(imem_inst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
    .out_pc(out_pc), .out_pc_plus4(out_pc_plus4)
  );

  always #5 clk = ~clk;

  // Big-endian byte memory decoding addr[9:0]
  logic [7:0] mem [1024];
  logic [9:0] idx;
  assign idx       = imem_addr[9:0];
  assign imem_inst = {mem[idx], mem[idx + 10'd1], mem[idx + 10'd2], mem[idx + 10'd3]};

  function automatic logic [31:0] word_at(input logic [9:0] a);
    if (a == 10'd0) return 32'h8C22_0000;
    if (a == 10'd4) return 32'h0022_1820;
    return {8'hA5, 14'h0, a};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rst;
    logic        rdv;
    logic [31:0] rpc;
    logic        rdy;
    logic        chk;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] eaddr;
    logic        zh;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic rv, input logic [31:0] rp, input logic rd,
                     input logic c, input logic ev, input logic [31:0] ep,
                     input logic [31:0] ea, input logic zh);
    vec_t v;
    v.rst = r; v.rdv = rv; v.rpc = rp; v.rdy = rd; v.chk = c;
    v.ev = ev; v.epc = ep; v.eaddr = ea; v.zh = zh;
    vecs.push_back(v);
  endtask

  initial begin
    logic [31:0] w;
    logic [31:0] exp_next;
    logic [31:0] held_pc;
    logic        hold;
    logic        r;
    int          pops;

    for (int a = 0; a < 1024; a += 4) begin
      w = word_at(10'(a));
      mem[a] = w[31:24]; mem[a+1] = w[23:16]; mem[a+2] = w[15:8]; mem[a+3] = w[7:0];
    end

    //   rst rdv rpc           rdy chk ev  epc           eaddr         zh
    add(1, 0, 32'h0,          1,  0, 0, 32'h0,          32'h0,          0); // v0
    add(0, 0, 32'h0,          1,  1, 0, 32'h0,          32'h0,          1); // cycle 0
    add(0, 0, 32'h0,          1,  1, 1, 32'h0,          32'h4,          0); // cycle 1: LW
    add(0, 0, 32'h0,          1,  1, 1, 32'h4,          32'h8,          0); // cycle 2: ADD
    add(1, 0, 32'h0,          1,  1, 1, 32'h8,          32'hC,          0);
    add(0, 0, 32'h0,          0,  1, 0, 32'h0,          32'h0,          1); // backpressure
    add(0, 0, 32'h0,          0,  1, 1, 32'h0,          32'h4,          0);
    add(0, 0, 32'h0,          0,  1, 1, 32'h0,          32'h8,          0); // full
    add(0, 0, 32'h0,          1,  1, 1, 32'h0,          32'h8,          0); // held, release
    add(0, 0, 32'h0,          1,  1, 1, 32'h4,          32'hC,          0);
    add(0, 0, 32'h0,          1,  1, 1, 32'h8,          32'h10,         0);
    add(0, 1, 32'h40,         0,  1, 1, 32'hC,          32'h14,         0); // redirect full
    add(0, 0, 32'h0,          0,  1, 0, 32'h0,          32'h40,         0);
    add(0, 1, 32'h83,         1,  1, 1, 32'h40,         32'h44,         0); // redirect + pop
    add(0, 0, 32'h0,          1,  1, 0, 32'h0,          32'h80,         0);
    add(0, 0, 32'h0,          1,  1, 1, 32'h80,         32'h84,         0);
    add(0, 1, 32'h100,        1,  1, 1, 32'h84,         32'h88,         0); // back-to-back
    add(0, 1, 32'h200,        1,  1, 0, 32'h0,          32'h100,        0);
    add(0, 0, 32'h0,          1,  1, 0, 32'h0,          32'h200,        0);
    add(0, 1, 32'h1000_0410,  1,  1, 1, 32'h200,        32'h204,        0); // alias
    add(0, 0, 32'h0,          1,  1, 0, 32'h0,          32'h1000_0410,  0);
    add(0, 1, 32'hFFFF_FFFC,  1,  1, 1, 32'h1000_0410,  32'h1000_0414,  0); // wrap
    add(0, 0, 32'h0,          1,  1, 0, 32'h0,          32'hFFFF_FFFC,  0);
    add(0, 0, 32'h0,          1,  1, 1, 32'hFFFF_FFFC,  32'h0,          0);
    add(0, 1, 32'h18,         1,  1, 1, 32'h0,          32'h4,          0);
    add(0, 0, 32'h0,          1,  1, 0, 32'h0,          32'h18,         0);
    add(0, 0, 32'h0,          1,  1, 1, 32'h18,         32'h1C,         0);
    add(1, 0, 32'h0,          1,  1, 1, 32'h1C,         32'h20,         0); // reset mid-stream
    add(1, 1, 32'h300,        1,  1, 0, 32'h0,          32'h0,          1); // reset beats redirect
    add(0, 0, 32'h0,          1,  1, 0, 32'h0,          32'h0,          1);
    add(0, 0, 32'h0,          1,  1, 1, 32'h0,          32'h4,          0);

    foreach (vecs[i]) begin
      @(negedge clk);
      if (vecs[i].chk) begin
        $display("vec %0d: valid=%0b pc=%08h inst=%08h addr=%08h", i, out_valid, out_pc, out_inst, imem_addr);
        check($sformatf("v%0d valid", i), {31'b0, out_valid}, {31'b0, vecs[i].ev});
        check($sformatf("v%0d imem_addr", i), imem_addr, vecs[i].eaddr);
        if (vecs[i].ev) begin
          check($sformatf("v%0d out_pc", i), out_pc, vecs[i].epc);
          check($sformatf("v%0d out_inst", i), out_inst, word_at(vecs[i].epc[9:0]));
          check($sformatf("v%0d out_pc_plus4", i), out_pc_plus4, vecs[i].epc + 32'd4);
        end
        if (vecs[i].zh) begin
          check($sformatf("v%0d reset out_pc", i), out_pc, 32'h0);
          check($sformatf("v%0d reset out_inst", i), out_inst, 32'h0);
        end
      end
      rst            = vecs[i].rst;
      redirect_valid = vecs[i].rdv;
      redirect_pc    = vecs[i].rpc;
      out_ready      = vecs[i].rdy;
    end

    // Random backpressure: in-order, gap-free, stable while stalled
    @(negedge clk);
    rst = 1'b1; redirect_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    exp_next = 32'h0; hold = 1'b0; held_pc = '0; pops = 0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (hold) begin
        check("stall valid", {31'b0, out_valid}, 32'h1);
        check("stall out_pc", out_pc, held_pc);
      end
      r = 1'($urandom_range(0, 1));
      out_ready = r;
      if (out_valid && r) begin
        $display("pop %0d: pc=%08h inst=%08h", pops, out_pc, out_inst);
        check("stream out_pc", out_pc, exp_next);
        check("stream out_inst", out_inst, word_at(exp_next[9:0]));
        exp_next = exp_next + 32'd4;
        pops++;
      end
      hold    = out_valid && !r;
      held_pc = out_pc;
    end
    n_checks++;
    if (pops < 10) begin
      n_fail++;
      $display("FAIL stream progress: got %0d pops expected at least 10", pops);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
